lms_train_ctrl: RTL and testbench

- Sequences one LMS adaptive-filter instance through coefficient clear, pipeline flush, reference-driven training and free-running tracking.
- Drives the filter's error-source select (is_out_ref) and coefficient clear (lms_clr).
- Monitors the filter error to declare convergence or training failure.
- Sits beside the LMS datapath, under control of the system sequencer.

---
 rtl/lms_train_ctrl.sv | 141 ++++++++++++++
 tb/tb_lms_train_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lms_train_ctrl.sv
// Training sequencer for one LMS filter: clear coefficients, flush, train against reference, then track.
// Registered outputs; watches |err_in| against thresh to declare convergence or budget failure.
module lms_train_ctrl #(
  parameter int DAT_W     = 16,
  parameter int CLR_CYC   = 4,
  parameter int FLUSH_LEN = 37,
  parameter int CONV_CNT  = 64,
  parameter int MAX_TRAIN = 4096,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             sample_vld,
  input  logic [DAT_W-1:0] err_in,
  input  logic [DAT_W-1:0] thresh,
  output logic             lms_clr,
  output logic             is_out_ref,
  output logic [2:0]       state,
  output logic             busy,
  output logic             converged,
  output logic             train_fail,
  output logic [CNT_W-1:0] train_cnt
);

  localparam int CCW = $clog2(CLR_CYC + 1);
  localparam int FW  = $clog2(FLUSH_LEN + 1);
  localparam int GW  = $clog2(CONV_CNT + 1);
  localparam int TW  = $clog2(MAX_TRAIN + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FLUSH = 3'd2,
    S_TRAIN = 3'd3,
    S_TRACK = 3'd4,
    S_FAIL  = 3'd5
  } state_t;

  state_t           state_q, state_nxt;
  logic [CCW-1:0]   clr_q, clr_nxt;
  logic [FW-1:0]    flush_q, flush_nxt;
  logic [GW-1:0]    good_q, good_nxt, good_inc;
  logic [TW-1:0]    trn_q, trn_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             conv_nxt, fail_nxt;
  logic [DAT_W-1:0] mag;

  // Two's-complement negate of the most-negative value yields 2^(DAT_W-1) as unsigned.
  assign mag      = err_in[DAT_W-1] ? (~err_in + 1'b1) : err_in;
  assign good_inc = (mag < thresh) ? good_q + 1'b1 : '0;
  assign state    = state_q;

  always_comb begin
    state_nxt = state_q;
    clr_nxt   = clr_q;
    flush_nxt = flush_q;
    good_nxt  = good_q;
    trn_nxt   = trn_q;
    cnt_nxt   = train_cnt;
    conv_nxt  = converged;
    fail_nxt  = train_fail;
    if (abort || start) begin
      state_nxt = abort ? S_IDLE : S_CLEAR;
      clr_nxt   = '0;
      flush_nxt = '0;
      good_nxt  = '0;
      trn_nxt   = '0;
      cnt_nxt   = '0;
      conv_nxt  = 1'b0;
      fail_nxt  = 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (clr_q == CCW'(CLR_CYC - 1)) begin
            state_nxt = S_FLUSH;
            clr_nxt   = '0;
          end else begin
            clr_nxt = clr_q + 1'b1;
          end
        end
        S_FLUSH: begin
          if (sample_vld) begin
            if (flush_q == FW'(FLUSH_LEN - 1)) begin
              state_nxt = S_TRAIN;
              flush_nxt = '0;
            end else begin
              flush_nxt = flush_q + 1'b1;
            end
          end
        end
        S_TRAIN: begin
          if (sample_vld) begin
            if (train_cnt != {CNT_W{1'b1}}) cnt_nxt = train_cnt + 1'b1;
            trn_nxt  = trn_q + 1'b1;
            good_nxt = good_inc;
            // Convergence is checked first so it wins on the budget's last sample.
            if (good_inc == GW'(CONV_CNT)) begin
              state_nxt = S_TRACK;
              conv_nxt  = 1'b1;
            end else if (trn_q + 1'b1 == TW'(MAX_TRAIN)) begin
              state_nxt = S_FAIL;
              fail_nxt  = 1'b1;
            end
          end
        end
        default: state_nxt = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clr_q      <= '0;
      flush_q    <= '0;
      good_q     <= '0;
      trn_q      <= '0;
      train_cnt  <= '0;
      converged  <= 1'b0;
      train_fail <= 1'b0;
      lms_clr    <= 1'b0;
      is_out_ref <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      clr_q      <= clr_nxt;
      flush_q    <= flush_nxt;
      good_q     <= good_nxt;
      trn_q      <= trn_nxt;
      train_cnt  <= cnt_nxt;
      converged  <= conv_nxt;
      train_fail <= fail_nxt;
      lms_clr    <= (state_nxt == S_CLEAR);
      is_out_ref <= (state_nxt == S_FLUSH) || (state_nxt == S_TRAIN);
      busy       <= (state_nxt == S_CLEAR) || (state_nxt == S_FLUSH) || (state_nxt == S_TRAIN);
    end
  end

endmodule

// File: tb/tb_lms_train_ctrl.sv
// Directed bench for lms_train_ctrl: table of training scenarios plus hand-written abort/restart/reset sequences.
module tb_lms_train_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        sample_vld = 1'b0;
  logic [15:0] err_in = '0;
  logic [15:0] thresh = '0;
  logic        lms_clr, is_out_ref, busy, converged, train_fail;
  logic [2:0]  state;
  logic [15:0] train_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  lms_train_ctrl #(
    .DAT_W(16), .CLR_CYC(4), .FLUSH_LEN(37), .CONV_CNT(8), .MAX_TRAIN(100), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sample_vld(sample_vld),
    .err_in(err_in), .thresh(thresh), .lms_clr(lms_clr), .is_out_ref(is_out_ref),
    .state(state), .busy(busy), .converged(converged), .train_fail(train_fail),
    .train_cnt(train_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] thr;
    logic [15:0] err_a; int n_a;
    logic [15:0] err_b; int n_b;
    logic [15:0] err_c; int n_c;
    logic [2:0]  exp_state;
    logic        exp_conv;
    logic        exp_fail;
    int          exp_cnt;
  } scen_t;

  scen_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] e);
    err_in = e;
    sample_vld = 1'b1;
    tick();
    sample_vld = 1'b0;
    tick();
  endtask

  // Pulse start, then measure how many cycles lms_clr stays high.
  task automatic do_start(input string tag);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " state=CLEAR"}, 32'(state), 1);
    chk({tag, " conv cleared"}, 32'(converged), 0);
    chk({tag, " fail cleared"}, 32'(train_fail), 0);
    chk({tag, " cnt cleared"}, 32'(train_cnt), 0);
    n = 0;
    while (lms_clr === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk({tag, " lms_clr cycles"}, 32'(n), 4);
    chk({tag, " state=FLUSH"}, 32'(state), 2);
    chk({tag, " is_out_ref flush"}, 32'(is_out_ref), 1);
  endtask

  task automatic do_flush(input string tag);
    for (int i = 0; i < 37; i++) begin
      strobe(16'h7FFF);
      if (i == 35) chk({tag, " flush 36 still FLUSH"}, 32'(state), 2);
    end
    chk({tag, " state=TRAIN"}, 32'(state), 3);
    chk({tag, " busy in TRAIN"}, 32'(busy), 1);
  endtask

  task automatic run_scen(input scen_t s);
    int total, k;
    logic [15:0] e;
    thresh = s.thr;
    do_start(s.name);
    do_flush(s.name);
    total = s.n_a + s.n_b + s.n_c;
    k = 0;
    for (int seg = 0; seg < 3; seg++) begin
      int n;
      n = (seg == 0) ? s.n_a : (seg == 1) ? s.n_b : s.n_c;
      e = (seg == 0) ? s.err_a : (seg == 1) ? s.err_b : s.err_c;
      for (int j = 0; j < n; j++) begin
        if (k == total - 1) chk({s.name, " pre-last TRAIN"}, 32'(state), 3);
        strobe(e);
        k++;
      end
    end
    chk({s.name, " end state"}, 32'(state), 32'(s.exp_state));
    chk({s.name, " converged"}, 32'(converged), 32'(s.exp_conv));
    chk({s.name, " train_fail"}, 32'(train_fail), 32'(s.exp_fail));
    chk({s.name, " train_cnt"}, 32'(train_cnt), 32'(s.exp_cnt));
    chk({s.name, " is_out_ref"}, 32'(is_out_ref), 0);
    chk({s.name, " busy"}, 32'(busy), 0);
    for (int j = 0; j < 3; j++) strobe(16'h0000);
    chk({s.name, " hold state"}, 32'(state), 32'(s.exp_state));
    chk({s.name, " hold cnt"}, 32'(train_cnt), 32'(s.exp_cnt));
  endtask

  initial begin
    tbl[0] = '{"nominal",   16'd10,   16'd5,    8,  16'd0, 0, 16'd0,    0, 3'd4, 1'b1, 1'b0, 8};
    tbl[1] = '{"boundary",  16'd10,   16'hFFF7, 7,  16'd10, 1, 16'hFFF7, 8, 3'd4, 1'b1, 1'b0, 16};
    tbl[2] = '{"budget",    16'd0,    16'h8000, 100, 16'd0, 0, 16'd0,   0, 3'd5, 1'b0, 1'b1, 100};
    tbl[3] = '{"simul",     16'd10,   16'd20,   92, 16'd0, 8, 16'd0,    0, 3'd4, 1'b1, 1'b0, 100};
    tbl[4] = '{"negmax_lt", 16'h8001, 16'h8000, 8,  16'd0, 0, 16'd0,    0, 3'd4, 1'b1, 1'b0, 8};
    tbl[5] = '{"negmax_eq", 16'h8000, 16'h8000, 100, 16'd0, 0, 16'd0,   0, 3'd5, 1'b0, 1'b1, 100};
    tbl[6] = '{"near_miss", 16'd10,   16'd20,   93, 16'd0, 7, 16'd0,    0, 3'd5, 1'b0, 1'b1, 100};

    #1;
    chk("reset state", 32'(state), 0);
    chk("reset lms_clr", 32'(lms_clr), 0);
    chk("reset is_out_ref", 32'(is_out_ref), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset flags", 32'({converged, train_fail}), 0);
    chk("reset train_cnt", 32'(train_cnt), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    strobe(16'd0);
    chk("idle ignores vld", 32'(state), 0);

    for (int i = 0; i < 7; i++) run_scen(tbl[i]);

    // Abort+start together in TRAIN, after a stall with no strobes.
    thresh = 16'd10;
    do_start("abort");
    do_flush("abort");
    for (int j = 0; j < 3; j++) strobe(16'd5);
    chk("abort cnt3", 32'(train_cnt), 3);
    for (int j = 0; j < 20; j++) tick();
    chk("stall holds TRAIN", 32'(state), 3);
    chk("stall holds cnt", 32'(train_cnt), 3);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort wins state", 32'(state), 0);
    chk("abort cnt", 32'(train_cnt), 0);
    chk("abort flags", 32'({converged, train_fail}), 0);
    chk("abort no clr", 32'({lms_clr, busy, is_out_ref}), 0);

    run_scen(tbl[0]);
    do_start("restart from TRACK");

    // Second start two cycles into CLEAR must restart the count.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    do_start("restart in CLEAR");

    // Async reset during CLEAR cycle 2.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre-reset lms_clr", 32'(lms_clr), 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst lms_clr", 32'(lms_clr), 0);
    chk("async rst state", 32'(state), 0);
    chk("async rst busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post-reset state", 32'(state), 0);
    chk("post-reset lms_clr", 32'(lms_clr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
